// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared ALU op codes, input-select/enable constants and sequencer state encoding
package alu_seq_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 16;
    localparam int unsigned ALU_OP_WIDTH   = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOT = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_INC = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DEC = 4'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NEG = 4'd8;

    localparam logic ALU_SEL_IN1 = 1'b0;
    localparam logic ALU_SEL_IN2 = 1'b1;
    localparam logic ALU_EN_ON   = 1'b1;
    localparam logic ALU_EN_OFF  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_CAPT   = 3'd4,
        ST_RESP   = 3'd5
    } seq_state_e;

    // Undefined codes are pass-through of input 1, so they only need operand A.
    function automatic logic alu_op_is_unary(input logic [ALU_OP_WIDTH-1:0] op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - request/response sequencer that serialises operands onto the ALU shared input bus
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_WIDTH-1:0]   req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  alu_en,
    output logic                  alu_in_select,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_in,
    input  logic [DATA_WIDTH-1:0] alu_out
);

    seq_state_e            state_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  alu_en_q;
    logic                  alu_sel_q;
    logic [DATA_WIDTH-1:0] alu_in_q;

    // Operand A goes straight into the bus register on accept; alu_in_q holds it through LOAD_A.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            b_q         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            alu_en_q    <= ALU_EN_OFF;
            alu_sel_q   <= ALU_SEL_IN1;
            alu_in_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        b_q         <= req_b;
                        req_ready_q <= 1'b0;
                        alu_en_q    <= ALU_EN_ON;
                        alu_sel_q   <= ALU_SEL_IN1;
                        alu_in_q    <= req_a;
                        state_q     <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (alu_op_is_unary(op_q)) begin
                        alu_en_q <= ALU_EN_OFF;
                        state_q  <= ST_EXEC;
                    end else begin
                        alu_en_q  <= ALU_EN_ON;
                        alu_sel_q <= ALU_SEL_IN2;
                        alu_in_q  <= b_q;
                        state_q   <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    alu_en_q <= ALU_EN_OFF;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    state_q <= ST_CAPT;
                end
                ST_CAPT: begin
                    rsp_data_q  <= alu_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    alu_en_q    <= ALU_EN_OFF;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign alu_en        = alu_en_q;
    assign alu_in_select = alu_sel_q;
    assign alu_op        = op_q;
    assign alu_in        = alu_in_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Request sequencer that sits directly upstream of the ALU.
- Accepts one operation per valid/ready handshake (op, operand A, operand B).
- Serialises the operands onto the ALU's shared single input bus using its enable/select protocol, holds the op code while the ALU computes, and returns the result over a valid/ready response port.
- Lets the decode/issue logic treat the ALU as a simple request/response unit.

Parameters:
- DATA_WIDTH, 16, operand/result width; must equal the ALU data width.
- OP_WIDTH, 4, op-code width; must equal the ALU op width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  OP_WIDTH  ALU op code (shared ALU op constants).
- req_a  in  DATA_WIDTH  operand A (loaded into ALU input 1).
- req_b  in  DATA_WIDTH  operand B (loaded into ALU input 2; ignored for unary ops).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DATA_WIDTH  registered result.
- alu_en  out  1  ALU input-load enable.
- alu_in_select  out  1  ALU input select (input 1 / input 2 constants).
- alu_op  out  OP_WIDTH  op code to ALU.
- alu_in  out  DATA_WIDTH  ALU shared input bus.
- alu_out  in  DATA_WIDTH  ALU result; updates every clock from the ALU's current inputs and op.

Behaviour:
- Interface is fixed: one clock, clk; synchronous active-high reset, rst.
- Reset: state=IDLE; req_ready=1, rsp_valid=0, rsp_data=0, alu_en=0, alu_in_select=input-1 constant, alu_op=0, alu_in=0. Holding registers op/a/b cleared to 0.
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, register op/a/b -> LOAD_A.
  - LOAD_A: alu_en=1, alu_in_select=input 1, alu_in=a. Next state is EXEC if op is unary (INC, DEC, NOT, NEG, or any code outside the defined set, i.e. pass-through); otherwise LOAD_B.
  - LOAD_B: alu_en=1, alu_in_select=input 2, alu_in=b -> EXEC.
  - EXEC: alu_en=0. ALU computes from its loaded inputs at this edge -> CAPT.
  - CAPT: rsp_data <= alu_out -> RESP.
  - RESP: rsp_valid=1, rsp_data stable. On rsp_ready -> IDLE.
- alu_op: driven from the held op register from accept until return to IDLE. Never changes while the ALU is loading or computing.
- alu_en: is 0 in every state except LOAD_A/LOAD_B, so ALU inputs are never disturbed outside a load.
- Latency, counting the accept edge as edge 0:
  - Binary op: rsp_valid rises after edge 4.
  - Unary op: rsp_valid rises after edge 3.
  - req_ready returns the cycle after the response handshake. No pipelining, one op in flight.
- Arithmetic: performed entirely by the ALU; results wrap modulo 2^DATA_WIDTH. The sequencer does no width extension.
- Backpressure: rsp_valid held high and rsp_data held constant indefinitely while rsp_ready=0. req_ready stays 0.
- Simultaneous events: req_valid in non-IDLE states is ignored. The request stays pending until the next IDLE.
- Reset mid-operation: returns to IDLE next edge and drops any in-flight result. ALU internal inputs are left untouched; the next binary op reloads both inputs, and a unary op reloads input 1.

Decomposition:
- ALU op codes, input-select and enable constants come from the shared ALU definitions header. Add a unary-op classification macro there.
- State encoding constants go in a new alu_seq header beside it.
- No sub-module needed: single FSM plus holding registers.

Test Plan (DATA_WIDTH=16, sequencer driving a real ALU instance):
- ADD a=0x0003 b=0x0004, rsp_ready=1 -> rsp_data=0x0007. rsp_valid high 4 cycles after accept. alu_en high exactly 2 cycles: input 1 then input 2.
- SUB a=0x0000 b=0x0001 -> rsp_data=0xFFFF (wrap).
- INC a=0xFFFF, b=0x1234 -> rsp_data=0x0000. Latency 3. alu_en high 1 cycle; ALU input 2 never loaded with 0x1234.
- AND a=0xF0F0 b=0x0FF0 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data=0x00F0 stable throughout. req_ready=0 while a second req_valid is held. Second request accepted the cycle after the handshake.
- Start XOR, assert rst during LOAD_B -> next cycle IDLE, rsp_valid=0, req_ready=1. Then NEG a=0x0001 -> rsp_data=0xFFFF.
- Back-to-back OR 0x00FF|0xFF00 then NOT 0x00FF -> 0xFFFF then 0xFF00, in order. alu_op constant during each op's LOAD/EXEC window.
